pipe_reg_file: RTL and testbench

PIPE_REG_FILE -- requirements
Module: pipe_reg_file

---
 rtl/rf_pkg.sv | 16 +
 rtl/pipe_reg_file_if.sv | 31 +++
 rtl/rf_scoreboard.sv | 44 ++++
 rtl/pipe_reg_file.sv | 98 +++++++++
 tb/tb_pipe_reg_file.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and address-width helper for the pipelined register file
package rf_pkg;

  localparam int          RF_XLEN     = 32;
  localparam logic [31:0] RF_SP_INIT  = 32'h2ffc;
  localparam int          RF_HALT_REG = 17;
  localparam int          RF_HALT_VAL = 10;

  function automatic int rf_aw(input int nreg);
    int w;
    w = 0;
    while ((1 << w) < nreg) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/pipe_reg_file_if.sv
// rtl/pipe_reg_file_if.sv - read/write/alloc/ecall bundle between the pipeline and the register file
interface pipe_reg_file_if import rf_pkg::*; #(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = rf_aw(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                is_ecall;
  logic                ecall_wait;
  logic                is_halted;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, is_ecall,
    input  rd_data, rd_busy, ecall_wait, is_halted
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, is_ecall,
    output rd_data, rd_busy, ecall_wait, is_halted
  );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write bits with set-over-clear priority and read lookup
module rf_scoreboard #(
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int AW       = 5,
  parameter int HALT_REG = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_en_i,
  input  logic [AW-1:0]     alloc_addr_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o,
  output logic              halt_busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clear first so an allocation in the same cycle re-marks the register pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) busy_d[wr_addr_i] = 1'b0;
    if (alloc_en_i && alloc_addr_i != '0) busy_d[alloc_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy_o[i] = busy_q[rd_addr_i[i*AW +: AW]];
    end
  end

  assign halt_busy_o = busy_q[HALT_REG];

endmodule

// File: rtl/pipe_reg_file.sv
// rtl/pipe_reg_file.sv - multi-port register file with busy tracking and ECALL halt detection
// Optional same-cycle write-to-read forwarding: RF_BYPASS_EN.
module pipe_reg_file import rf_pkg::*; #(
  parameter int              XLEN     = RF_XLEN,
  parameter int              NREG     = 32,
  parameter int              NRD      = 2,
  parameter logic [XLEN-1:0] SP_INIT  = XLEN'(RF_SP_INIT),
  parameter int              HALT_REG = RF_HALT_REG,
  parameter int              HALT_VAL = RF_HALT_VAL
) (
  input  logic             clk,
  input  logic             reset,
  pipe_reg_file_if.slave   bus
);

  localparam int            AW        = rf_aw(NREG);
  localparam logic [AW-1:0] HALT_ADDR = AW'(HALT_REG);

  logic [XLEN-1:0]     regs_q [NREG];
  logic                halted_q;
  logic [NRD-1:0]      sb_busy;
  logic                sb_halt_busy;
  logic                wr_live;
  logic [NRD*XLEN-1:0] rd_data_c;
  logic [NRD-1:0]      rd_busy_c;
  logic [XLEN-1:0]     halt_val_c;
  logic                halt_busy_c;
  logic                halt_fire;

  assign wr_live = bus.wr_en && (bus.wr_addr != '0);

  rf_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .AW       (AW),
    .HALT_REG (HALT_REG)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .alloc_en_i   (bus.alloc_en),
    .alloc_addr_i (bus.alloc_addr),
    .wr_en_i      (bus.wr_en),
    .wr_addr_i    (bus.wr_addr),
    .rd_addr_i    (bus.rd_addr),
    .rd_busy_o    (sb_busy),
    .halt_busy_o  (sb_halt_busy)
  );

  always_comb begin
    logic [AW-1:0] a;
    a         = '0;
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int i = 0; i < NRD; i++) begin
      a = bus.rd_addr[i*AW +: AW];
      rd_data_c[i*XLEN +: XLEN] = (a == '0) ? '0 : regs_q[a];
      rd_busy_c[i]              = sb_busy[i];
`ifdef RF_BYPASS_EN
      if (wr_live && bus.wr_addr == a) begin
        rd_data_c[i*XLEN +: XLEN] = bus.wr_data;
        rd_busy_c[i]              = 1'b0;
      end
`endif
    end
  end

  // The halt check sees HALT_REG exactly as a read port would.
  always_comb begin
    halt_val_c  = regs_q[HALT_ADDR];
    halt_busy_c = sb_halt_busy;
`ifdef RF_BYPASS_EN
    if (wr_live && bus.wr_addr == HALT_ADDR) begin
      halt_val_c  = bus.wr_data;
      halt_busy_c = 1'b0;
    end
`endif
  end

  assign halt_fire = bus.is_ecall && !halt_busy_c && (halt_val_c == XLEN'(HALT_VAL));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= (r == 2) ? SP_INIT : '0;
      end
      halted_q <= 1'b0;
    end else begin
      if (wr_live)   regs_q[bus.wr_addr] <= bus.wr_data;
      if (halt_fire) halted_q            <= 1'b1;
    end
  end

  assign bus.rd_data    = rd_data_c;
  assign bus.rd_busy    = rd_busy_c;
  assign bus.ecall_wait = bus.is_ecall && halt_busy_c;
  assign bus.is_halted  = halted_q;

endmodule

// File: tb/tb_pipe_reg_file.sv
// tb/tb_pipe_reg_file.sv - directed and randomized checks of pipe_reg_file against a reference model
module tb_pipe_reg_file;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_halted;

  pipe_reg_file_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();

  pipe_reg_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void exp_port(input int a, output logic [31:0] d, output logic b);
    d = (a == 0) ? 32'd0 : m_regs[a];
    b = m_busy[a];
`ifdef RF_BYPASS_EN
    if (bus.wr_en && bus.wr_addr != 0 && int'(bus.wr_addr) == a) begin
      d = bus.wr_data;
      b = 1'b0;
    end
`endif
  endfunction

  task automatic model_tick();
    logic [31:0] hv;
    logic        hb;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = 32'd0;
        m_busy[r] = 1'b0;
      end
      m_regs[2] = 32'h2ffc;
      m_halted  = 1'b0;
    end else begin
      exp_port(17, hv, hb);
      if (bus.is_ecall && !hb && hv == 32'd10) m_halted = 1'b1;
      if (bus.wr_en && bus.wr_addr != 0) m_regs[bus.wr_addr] = bus.wr_data;
      if (bus.wr_en) m_busy[bus.wr_addr] = 1'b0;
      if (bus.alloc_en && bus.alloc_addr != 0) m_busy[bus.alloc_addr] = 1'b1;
    end
  endtask

  task automatic step();
    model_tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset          = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = '0;
    bus.is_ecall   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    idle_inputs();
    bus.rd_addr = {5'd5, 5'd2};
    #1;
    total++;
    if (bus.rd_data[31:0] !== 32'h2ffc) begin
      bad++; $display("FAIL reset_x2 got=%h exp=%h", bus.rd_data[31:0], 32'h2ffc);
    end
    total++;
    if (bus.rd_data[63:32] !== 32'h0) begin
      bad++; $display("FAIL reset_x5 got=%h exp=0", bus.rd_data[63:32]);
    end
    total++;
    if (bus.rd_busy !== 2'b00) begin
      bad++; $display("FAIL reset_busy got=%b exp=00", bus.rd_busy);
    end
    total++;
    if (bus.is_halted !== 1'b0) begin
      bad++; $display("FAIL reset_halted got=%b exp=0", bus.is_halted);
    end
    step();
  endtask

  task automatic test_x0();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hdead;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd0;
    step();
    idle_inputs();
    bus.rd_addr = {5'd0, 5'd0};
    #1;
    total++;
    if (bus.rd_data !== 64'd0) begin
      bad++; $display("FAIL x0_data got=%h exp=0", bus.rd_data);
    end
    total++;
    if (bus.rd_busy !== 2'b00) begin
      bad++; $display("FAIL x0_busy got=%b exp=00", bus.rd_busy);
    end
    step();
  endtask

  task automatic test_bypass();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd7;
    step();
    idle_inputs();
    bus.rd_addr = {5'd2, 5'd7};
    #1;
    total++;
    if (bus.rd_busy[0] !== 1'b1) begin
      bad++; $display("FAIL alloc_x7_busy got=%b exp=1", bus.rd_busy[0]);
    end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'd5;
    #1;
`ifdef RF_BYPASS_EN
    total++;
    if (bus.rd_data[31:0] !== 32'd5 || bus.rd_busy[0] !== 1'b0) begin
      bad++; $display("FAIL bypass_x7 got=%h/%b exp=5/0", bus.rd_data[31:0], bus.rd_busy[0]);
    end
`else
    total++;
    if (bus.rd_data[31:0] !== 32'd0 || bus.rd_busy[0] !== 1'b1) begin
      bad++; $display("FAIL nobypass_x7 got=%h/%b exp=0/1", bus.rd_data[31:0], bus.rd_busy[0]);
    end
`endif
    step();
    idle_inputs();
    #1;
    total++;
    if (bus.rd_data[31:0] !== 32'd5 || bus.rd_busy[0] !== 1'b0) begin
      bad++; $display("FAIL after_wr_x7 got=%h/%b exp=5/0", bus.rd_data[31:0], bus.rd_busy[0]);
    end
    step();
  endtask

  task automatic test_alloc_write_same();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h99;
    step();
    idle_inputs();
    bus.rd_addr = {5'd9, 5'd0};
    #1;
    total++;
    if (bus.rd_busy[1] !== 1'b1 || bus.rd_data[63:32] !== 32'h99) begin
      bad++; $display("FAIL set_wins_x9 got=%h/%b exp=99/1", bus.rd_data[63:32], bus.rd_busy[1]);
    end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h99;
    step();
    idle_inputs();
  endtask

  task automatic test_halt();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd17; bus.wr_data = 32'd10;
    step();
    idle_inputs();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd17;
    step();
    idle_inputs();
    bus.is_ecall = 1'b1;
    #1;
    total++;
    if (bus.ecall_wait !== 1'b1) begin
      bad++; $display("FAIL ecall_wait_pending got=%b exp=1", bus.ecall_wait);
    end
    step();
    idle_inputs();
    #1;
    total++;
    if (bus.is_halted !== 1'b0) begin
      bad++; $display("FAIL halted_while_pending got=%b exp=0", bus.is_halted);
    end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd17; bus.wr_data = 32'd10;
    step();
    idle_inputs();
    bus.is_ecall = 1'b1;
    #1;
    total++;
    if (bus.ecall_wait !== 1'b0 || bus.is_halted !== 1'b0) begin
      bad++; $display("FAIL ecall_ready got=%b/%b exp=0/0", bus.ecall_wait, bus.is_halted);
    end
    step();
    idle_inputs();
    #1;
    total++;
    if (bus.is_halted !== 1'b1) begin
      bad++; $display("FAIL halt_set got=%b exp=1", bus.is_halted);
    end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd17; bus.wr_data = 32'd3; bus.is_ecall = 1'b1;
    step();
    idle_inputs();
    step();
    #1;
    total++;
    if (bus.is_halted !== 1'b1) begin
      bad++; $display("FAIL halt_sticky got=%b exp=1", bus.is_halted);
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h1234;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9; bus.is_ecall = 1'b1;
    step();
    idle_inputs();
    bus.rd_addr = {5'd2, 5'd9};
    #1;
    total++;
    if (bus.rd_data[31:0] !== 32'd0 || bus.rd_busy[0] !== 1'b0) begin
      bad++; $display("FAIL rst_prio_x9 got=%h/%b exp=0/0", bus.rd_data[31:0], bus.rd_busy[0]);
    end
    total++;
    if (bus.is_halted !== 1'b0) begin
      bad++; $display("FAIL rst_prio_halted got=%b exp=0", bus.is_halted);
    end
    step();
  endtask

  function automatic logic [4:0] pick_addr();
    logic [4:0] hot [4];
    hot[0] = 5'd0; hot[1] = 5'd2; hot[2] = 5'd7; hot[3] = 5'd17;
    if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 31));
    return hot[$urandom_range(0, 3)];
  endfunction

  task automatic test_random();
    logic [31:0] ed;
    logic        eb;
    logic [31:0] hv;
    logic        hb;
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 59) == 0);
      bus.rd_addr    = {pick_addr(), pick_addr()};
      bus.wr_en      = 1'($urandom_range(0, 1));
      bus.wr_addr    = pick_addr();
      bus.wr_data    = ($urandom_range(0, 2) == 0) ? 32'd10 : $urandom;
      bus.alloc_en   = 1'($urandom_range(0, 1));
      bus.alloc_addr = pick_addr();
      bus.is_ecall   = ($urandom_range(0, 3) == 0);
      #1;
      for (int p = 0; p < 2; p++) begin
        exp_port(int'(bus.rd_addr[p*5 +: 5]), ed, eb);
        total++;
        if (bus.rd_data[p*32 +: 32] !== ed) begin
          bad++; $display("FAIL rnd_data n=%0d p=%0d got=%h exp=%h", n, p, bus.rd_data[p*32 +: 32], ed);
        end
        total++;
        if (bus.rd_busy[p] !== eb) begin
          bad++; $display("FAIL rnd_busy n=%0d p=%0d got=%b exp=%b", n, p, bus.rd_busy[p], eb);
        end
      end
      exp_port(17, hv, hb);
      total++;
      if (bus.ecall_wait !== (bus.is_ecall && hb)) begin
        bad++; $display("FAIL rnd_ecall_wait n=%0d got=%b exp=%b", n, bus.ecall_wait, bus.is_ecall && hb);
      end
      total++;
      if (bus.is_halted !== m_halted) begin
        bad++; $display("FAIL rnd_halted n=%0d got=%b exp=%b", n, bus.is_halted, m_halted);
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'd0;
      m_busy[r] = 1'b0;
    end
    m_halted    = 1'b0;
    bus.rd_addr = '0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_x0();
    test_bypass();
    test_alloc_write_same();
    test_halt();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
